mips_run_controller: RTL and testbench
======================================

Name: mips_run_controller

Overview:
Sequences one program run on the Mips32 core. It streams a program image into instruction memory while holding the core in reset, then releases the core. It watches `halted`, counts execution cycles and enforces a cycle budget. It sits between the host/testbench stream and the core plus its instruction memory, and replaces the free-running ResetDriver.

Parameters:
- IMEM_ADDR_W, 6: instruction-memory word-address width. MAX_WORDS = 2**IMEM_ADDR_W.
- RESET_HOLD, 7: number of cycles `core_reset` stays high after loading, before the core is released.
- CNT_W, 32: width of the cycle and word counters.
- TIMEOUT_CYCLES, 1024: run-cycle budget before the run is aborted.

Ports:
- clock, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: 1-cycle pulse that begins a load+run; honoured only in IDLE, DONE or TOUT.
- abort, in, 1: forces return to IDLE from any state.
- load_valid, in, 1: program beat valid.
- load_ready, out, 1: program beat accepted when load_valid && load_ready.
- load_data, in, 32: instruction word.
- load_last, in, 1: marks the final beat of the program.
- imem_wen, out, 1: instruction-memory write enable.
- imem_waddr, out, IMEM_ADDR_W: word address.
- imem_wdata, out, 32: write data.
- core_reset, out, 1: active-high synchronous reset to Mips32.
- core_halted, in, 1: Mips32 `halted`.
- busy, out, 1: high in LOAD, HOLD and RUN.
- done, out, 1: high in DONE.
- timeout, out, 1: high in TOUT.
- load_err, out, 1: sticky; image reached MAX_WORDS without load_last.
- word_count, out, CNT_W: number of beats accepted in the current load.
- cycle_count, out, CNT_W: number of RUN cycles.

Behaviour:
- Reset values: state=IDLE, core_reset=1, load_ready=0, imem_wen=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, timeout=0, load_err=0, word_count=0, cycle_count=0.
- All outputs are registered. load_ready, busy, done, timeout and core_reset are decoded from the registered state; core_reset = (state != RUN).
- States: IDLE, LOAD, HOLD, RUN, DONE, TOUT.
- IDLE/DONE/TOUT -> LOAD on start:
  - clears word_count, cycle_count and load_err;
  - load_ready is high in the first LOAD cycle.
- LOAD:
  - load_ready=1.
  - An accepted beat at edge e drives imem_wen=1, imem_waddr=word_count (pre-increment) and imem_wdata=load_data during cycle e+1; word_count increments.
  - Back-to-back beats are supported, one per cycle.
- LOAD exit: an accepted beat with load_last=1, or the accepted beat with index MAX_WORDS-1, goes to HOLD.
  - The latter without load_last sets load_err=1. The run still proceeds; no address wrap occurs.
  - Beats offered outside LOAD are not accepted (load_ready=0).
- HOLD:
  - Lasts exactly RESET_HOLD cycles (internal counter), then RUN.
  - The final imem write completes during the first HOLD cycle.
- RUN:
  - core_reset=0.
  - cycle_count increments on every RUN edge, including the edge at which core_halted is sampled high.
  - core_halted=1 -> DONE.
  - Otherwise, when the post-increment cycle_count == TIMEOUT_CYCLES -> TOUT, and core_reset reasserts.
  - Simultaneous halt and budget exhaustion: DONE wins.
- DONE/TOUT: hold cycle_count, word_count and load_err until the next start.
- abort: from any state, next state is IDLE.
  - Counters are held.
  - Any imem write already registered still completes in the following cycle.
  - abort has priority over start and over core_halted.
- start while busy is ignored.
- cycle_count saturates at all-ones; it cannot overflow with the default TIMEOUT_CYCLES.
- Asynchronous reset mid-LOAD or mid-RUN: immediate return to the reset values. core_reset=1 immediately on assertion.

Decomposition:
- Package mips_run_pkg holds:
  - the state enum (run_state_t: IDLE, LOAD, HOLD, RUN, DONE, TOUT);
  - localparams for the default widths;
  - the function for the MAX_WORDS computation.
- One sub-module, run_cycle_counter: a CNT_W saturating counter with clear, enable and a terminal-match output. It is instantiated twice: once as the HOLD timer and once as the run cycle counter.

Test Plan:
- Normal run. Reset low 3 cycles, then high; start; 5 back-to-back beats with last on beat 4 ->
  - imem writes to addresses 0..4, each one cycle after acceptance;
  - word_count=5;
  - core_reset high for exactly 7 cycles after the last write, then low;
  - core_halted raised after 20 RUN cycles -> done=1, cycle_count=20, busy=0.
- Throttled load. load_valid toggling every other cycle for 3 beats -> exactly 3 imem writes, no duplicates, addresses 0,1,2.
- Overflow. 64 beats with load_last never set -> load_err=1, the 64th beat written to address 63, HOLD entered, no 65th accept.
- Timeout, with TIMEOUT_CYCLES=1024. core_halted held 0 ->
  - timeout=1 at cycle_count=1024;
  - core_reset=1 from the following cycle.
  - A variant with halt on cycle 1024 -> done=1, timeout=0.
- abort mid-RUN at cycle 10 -> IDLE next cycle, core_reset=1, cycle_count holds 10. A subsequent start clears the counters and reloads.
- Async reset asserted mid-LOAD between clock edges -> outputs at reset values immediately; start ignored while reset is low.

Source files
------------

// File: rtl/mips_run_pkg.sv
// Shared types and defaults for the Mips32 program-run sequencer.
package mips_run_pkg;

  localparam int DEF_IMEM_ADDR_W    = 6;
  localparam int DEF_RESET_HOLD     = 7;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    TOUT = 3'd5
  } run_state_t;

  function automatic int max_words(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with clear and enable.
// hit flags the edge at which the post-increment value equals TERM.
module run_cycle_counter #(
  parameter int             W    = 32,
  parameter logic [W-1:0]   TERM = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] inc;

  assign inc = (count == {W{1'b1}}) ? count : count + {{(W-1){1'b0}}, 1'b1};
  assign hit = enable && !clear && (inc == TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= inc;
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Loads a program image into instruction memory with the core held in reset,
// then releases the core and bounds the run by a halt or a cycle budget.
module mips_run_controller
  import mips_run_pkg::*;
#(
  parameter int IMEM_ADDR_W    = DEF_IMEM_ADDR_W,
  parameter int RESET_HOLD     = DEF_RESET_HOLD,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [31:0]            load_data,
  input  logic                   load_last,
  output logic                   imem_wen,
  output logic [IMEM_ADDR_W-1:0] imem_waddr,
  output logic [31:0]            imem_wdata,
  output logic                   core_reset,
  input  logic                   core_halted,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   load_err,
  output logic [CNT_W-1:0]       word_count,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int               MAX_WORDS = max_words(IMEM_ADDR_W);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MAX_WORDS - 1);

  run_state_t       state, state_nxt;
  logic             accept, start_ok, at_last_idx, last_beat;
  logic             hold_hit, run_hit;
  logic [CNT_W-1:0] unused_hold_cnt;

  assign load_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == HOLD) || (state == RUN);
  assign done       = (state == DONE);
  assign timeout    = (state == TOUT);
  assign core_reset = (state != RUN);

  // Abort suppresses the handshake so every counter is frozen on that edge.
  assign accept      = load_valid && load_ready && !abort;
  assign start_ok    = start && !abort &&
                       ((state == IDLE) || (state == DONE) || (state == TOUT));
  assign at_last_idx = (word_count == LAST_IDX);
  assign last_beat   = accept && (load_last || at_last_idx);

  run_cycle_counter #(.W(CNT_W), .TERM(CNT_W'(RESET_HOLD))) u_hold_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != HOLD),
    .enable (state == HOLD),
    .count  (unused_hold_cnt),
    .hit    (hold_hit)
  );

  run_cycle_counter #(.W(CNT_W), .TERM(CNT_W'(TIMEOUT_CYCLES))) u_run_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok),
    .enable ((state == RUN) && !abort),
    .count  (cycle_count),
    .hit    (run_hit)
  );

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, TOUT: if (start) state_nxt = LOAD;
        LOAD:             if (last_beat) state_nxt = HOLD;
        HOLD:             if (hold_hit) state_nxt = RUN;
        RUN: begin
          // A halt on the budget's final edge still counts as a clean finish.
          if (core_halted)  state_nxt = DONE;
          else if (run_hit) state_nxt = TOUT;
        end
        default:          state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word_count <= '0;
      load_err   <= 1'b0;
      imem_wen   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      imem_wen <= accept;
      if (accept) begin
        imem_waddr <= word_count[IMEM_ADDR_W-1:0];
        imem_wdata <= load_data;
      end
      if (start_ok) begin
        word_count <= '0;
        load_err   <= 1'b0;
      end else if (accept) begin
        if (word_count != {CNT_W{1'b1}}) word_count <= word_count + 1'b1;
        if (at_last_idx && !load_last)   load_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller with hand-computed expectations.
module tb_mips_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start = 1'b0, abort = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, core_halted = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_ready, imem_wen, core_reset, busy, done, timeout, load_err;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata, word_count, cycle_count;

  int total = 0;
  int bad   = 0;
  int wr_total = 0;
  int base;
  int n;

  mips_run_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .imem_wen    (imem_wen),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .core_reset  (core_reset),
    .core_halted (core_halted),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .load_err    (load_err),
    .word_count  (word_count),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (imem_wen === 1'b1) wr_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cc(input logic [31:0] tgt);
    int k = 0;
    while (cycle_count !== tgt && k < 3000) begin
      step();
      k++;
    end
    check("wait_cc", cycle_count, tgt);
  endtask

  task automatic wait_run();
    int k = 0;
    while (core_reset !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    check("wait_run", 32'(core_reset), 0);
  endtask

  task automatic load_one(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) step();
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_load_ready", 32'(load_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_imem_wen", 32'(imem_wen), 0);
    check("rst_word_count", word_count, 0);
    check("rst_cycle_count", cycle_count, 0);

    // Normal run: 5 back-to-back beats, halt on the 20th RUN cycle.
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_ready_first", 32'(load_ready), 1);
    check("busy_load", 32'(busy), 1);
    base = wr_total;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA000_0000 + i;
      load_last  = (i == 4);
      step();
      check("norm_wen", 32'(imem_wen), 1);
      check("norm_waddr", 32'(imem_waddr), i);
      check("norm_wdata", imem_wdata, 32'hA000_0000 + i);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("hold_no_ready", 32'(load_ready), 0);
    check("norm_word_count", word_count, 5);
    n = 1;
    while (core_reset === 1'b1 && n < 50) begin
      step();
      if (core_reset === 1'b1) n++;
    end
    check("hold_len", n, 7);
    check("norm_writes", wr_total - base, 5);
    check("run_cc_start", cycle_count, 0);
    wait_cc(19);
    core_halted = 1'b1;
    step();
    core_halted = 1'b0;
    check("norm_done", 32'(done), 1);
    check("norm_cc", cycle_count, 20);
    check("norm_busy", 32'(busy), 0);
    check("norm_timeout", 32'(timeout), 0);
    check("norm_core_reset", 32'(core_reset), 1);

    // Throttled load: valid every other cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    base = wr_total;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b0;
      step();
      check("thr_gap_wen", 32'(imem_wen), 0);
      load_valid = 1'b1;
      load_data  = 32'hB0 + i;
      load_last  = (i == 2);
      step();
      check("thr_wen", 32'(imem_wen), 1);
      check("thr_waddr", 32'(imem_waddr), i);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    step();
    step();
    check("thr_writes", wr_total - base, 3);
    check("thr_word_count", word_count, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("thr_abort_busy", 32'(busy), 0);

    // Overflow: 64 beats with no last marker.
    start = 1'b1;
    step();
    start = 1'b0;
    base = wr_total;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC000_0000 + i;
      step();
    end
    check("ovf_waddr", 32'(imem_waddr), 63);
    check("ovf_wdata", imem_wdata, 32'hC000_003F);
    check("ovf_load_err", 32'(load_err), 1);
    check("ovf_word_count", word_count, 64);
    check("ovf_ready", 32'(load_ready), 0);
    step();
    step();
    load_valid = 1'b0;
    check("ovf_no_65th", word_count, 64);
    check("ovf_writes", wr_total - base, 64);

    // start ignored while running, then abort at cycle 10.
    wait_run();
    wait_cc(5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_ignored", cycle_count, 6);
    check("busy_start_no_load", 32'(load_ready), 0);
    wait_cc(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_core_reset", 32'(core_reset), 1);
    check("abort_cc", cycle_count, 10);
    step();
    check("abort_cc_held", cycle_count, 10);
    check("abort_load_err_held", 32'(load_err), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_cc", cycle_count, 0);
    check("restart_wc", word_count, 0);
    check("restart_load_err", 32'(load_err), 0);
    check("restart_ready", 32'(load_ready), 1);

    // Timeout with core_halted held low.
    load_one(32'hD0);
    wait_run();
    wait_cc(1023);
    check("tout_pre_core_reset", 32'(core_reset), 0);
    step();
    check("tout_timeout", 32'(timeout), 1);
    check("tout_cc", cycle_count, 1024);
    check("tout_core_reset", 32'(core_reset), 1);
    check("tout_done", 32'(done), 0);

    // Halt on the budget's final cycle: done wins.
    start = 1'b1;
    step();
    start = 1'b0;
    load_one(32'hD1);
    wait_run();
    wait_cc(1023);
    core_halted = 1'b1;
    step();
    core_halted = 1'b0;
    check("tie_done", 32'(done), 1);
    check("tie_timeout", 32'(timeout), 0);
    check("tie_cc", cycle_count, 1024);

    // Asynchronous reset between edges during LOAD.
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'hE0;
    load_last  = 1'b0;
    step();
    load_valid = 1'b0;
    check("ar_pre_wen", 32'(imem_wen), 1);
    check("ar_pre_wc", word_count, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_core_reset", 32'(core_reset), 1);
    check("ar_load_ready", 32'(load_ready), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_wen", 32'(imem_wen), 0);
    check("ar_waddr", 32'(imem_waddr), 0);
    check("ar_wdata", imem_wdata, 0);
    check("ar_wc", word_count, 0);
    check("ar_cc", cycle_count, 0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("ar_start_ignored", 32'(busy), 0);
    reset = 1'b1;
    step();
    check("ar_idle_after", 32'(load_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
